save_mtxreg_ddrwr_ctrl: RTL and testbench
=========================================

SAVE_MTXREG_DDRWR_CTRL -- requirements
Module: save_mtxreg_ddrwr_ctrl

Interface
REQ-001 Parameter DDRIF_DATA_WTH, default 512, sets the data beat width in bits.
REQ-002 Parameter ADDR_WTH, default 32, sets the DDR byte address width.
REQ-003 Parameter MAX_BURST, default 16, sets the maximum beats per burst (power of 2, 2..256).
REQ-004 Port clk_i, input, 1, is the single clock; all logic is rising-edge.
REQ-005 Port rstn_i, input, 1, is the reset: asynchronous assert, active-low.
REQ-006 Command ports: cmd_valid_i in 1, cmd_ready_o out 1, cmd_addr_i in ADDR_WTH (beat-aligned start address), cmd_len_i in 16 (total beats, 0 = no-op).
REQ-007 FIFO ports: mtxreg_data_empty_i in 1, mtxreg_data_re_o out 1, fifo_rdata_i in DDRIF_DATA_WTH (valid exactly 1 cycle after re).
REQ-008 AW ports: aw_valid_o out 1, aw_ready_i in 1, aw_addr_o out ADDR_WTH, aw_len_o out 8 (beats-1).
REQ-009 W ports: w_valid_o out 1, w_ready_i in 1, w_data_o out DDRIF_DATA_WTH, w_last_o out 1.
REQ-010 B ports: b_valid_i in 1, b_ready_o out 1, b_resp_i in 2.
REQ-011 Status ports: busy_o out 1, done_o out 1 (1-cycle pulse), err_o out 1 (sticky).

Function
REQ-012 The FSM SHALL have states IDLE, ADDR, DATA, RESP.
REQ-013 IDLE: cmd_ready_o=1; a handshake with cmd_len_i>0 latches address and remaining count, then goes to ADDR; cmd_len_i=0 pulses done_o the next cycle and stays in IDLE.
REQ-014 ADDR: aw_valid_o=1; aw_len_o=min(remaining,MAX_BURST)-1; aw_addr_o held stable until aw_ready_i; on handshake, go to DATA.
REQ-015 DATA: mtxreg_data_re_o=1 only when !mtxreg_data_empty_i, beats-read-this-burst < burst length, and the 2-entry output buffer has room counting the in-flight read.
REQ-016 Returned FIFO data SHALL enter the 2-entry output buffer; w_valid_o = buffer non-empty; w_data_o = buffer head; no bubble with continuous w_ready_i and a non-empty FIFO.
REQ-017 w_last_o SHALL assert on the final beat of the current burst; the w_last handshake moves the FSM to RESP.
REQ-018 RESP: b_ready_o=1; on b_valid_i, remaining -= burst length and address += burst length*DDRIF_DATA_WTH/8.
REQ-019 After the response, remaining>0 -> ADDR; remaining=0 -> IDLE with a done_o pulse in the same cycle.
REQ-020 Only one burst SHALL be outstanding; no AW issues before the prior B is received.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADDR_WTH; no 4 KB split is performed.
REQ-022 busy_o = (state != IDLE).
REQ-023 FIFO empty mid-burst: w_valid_o deasserts once the buffer drains; the burst resumes without loss.
REQ-024 w_valid_o and w_data_o SHALL hold stable while w_ready_i=0.

Reset
REQ-025 On rstn_i low: state=IDLE; all valid/ready/re/done outputs=0 (cmd_ready_o rises after release); counters, buffer, and err_o are cleared.
REQ-026 Reset mid-burst SHALL abort with no further FIFO reads; FIFO contents are not flushed by this block.

Configuration
REQ-027 With SVMR_BRESP_CHK_EN defined: b_resp_i != 0 sets err_o, and the command terminates after that response (IDLE, done_o pulse).
REQ-028 Without SVMR_BRESP_CHK_EN: b_resp_i is ignored and err_o is tied to 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the OKAY response constant (2'b00).
REQ-030 The 2-entry output buffer SHALL be the sub-module svmr_wbuf2 (write, pop, count, head data).

Verification
REQ-031 cmd_len=16, addr=0x1000, full FIFO, ready always 1 -> one AW (len=15, addr 0x1000); 16 W beats back-to-back; last on beat 16; done_o 1 cycle after B.
REQ-032 cmd_len=40, MAX_BURST=16 -> AW at 0x0, 0x400, 0x800 with len 15, 15, 7; done_o after the third B.
REQ-033 w_ready_i toggling 1-0 and FIFO empty for 5 cycles mid-burst -> data order is preserved, no duplicates or drops, w_data_o is stable while stalled.
REQ-034 cmd_len=0 -> no AW and no FIFO read; done_o pulses once.
REQ-035 SVMR_BRESP_CHK_EN, cmd_len=32, first b_resp=2'b10 -> err_o=1, no second AW, done_o pulse.
REQ-036 rstn_i low during beat 5 of 16 -> outputs 0 immediately; after release cmd_ready_o=1 and a new command runs correctly.

Source files
------------

// File: rtl/save_mtxreg_ddrwr_ctrl_pkg.sv
// Shared types for the matrix-register DDR write controller: FSM states and AXI response codes.
package save_mtxreg_ddrwr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } svmr_state_e;

    localparam logic [1:0] SVMR_RESP_OKAY = 2'b00;

endpackage

// File: rtl/save_mtxreg_ddrwr_ctrl_if.sv
// Bundle of command, source-FIFO and AXI write-channel signals; suffixes are from the controller's view.
interface save_mtxreg_ddrwr_ctrl_if #(
    parameter int DDRIF_DATA_WTH = 512,
    parameter int ADDR_WTH       = 32
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [ADDR_WTH-1:0]       cmd_addr_i;
    logic [15:0]               cmd_len_i;

    logic                      mtxreg_data_empty_i;
    logic                      mtxreg_data_re_o;
    logic [DDRIF_DATA_WTH-1:0] fifo_rdata_i;

    logic                      aw_valid_o;
    logic                      aw_ready_i;
    logic [ADDR_WTH-1:0]       aw_addr_o;
    logic [7:0]                aw_len_o;

    logic                      w_valid_o;
    logic                      w_ready_i;
    logic [DDRIF_DATA_WTH-1:0] w_data_o;
    logic                      w_last_o;

    logic                      b_valid_i;
    logic                      b_ready_o;
    logic [1:0]                b_resp_i;

    // master is the controller itself; slave is the surrounding command source, FIFO and AXI port
    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i,
        input  mtxreg_data_empty_i, fifo_rdata_i,
        input  aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
        output cmd_ready_o, mtxreg_data_re_o,
        output aw_valid_o, aw_addr_o, aw_len_o,
        output w_valid_o, w_data_o, w_last_o, b_ready_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_len_i,
        output mtxreg_data_empty_i, fifo_rdata_i,
        output aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
        input  cmd_ready_o, mtxreg_data_re_o,
        input  aw_valid_o, aw_addr_o, aw_len_o,
        input  w_valid_o, w_data_o, w_last_o, b_ready_o
    );

endinterface

// File: rtl/save_mtxreg_ddrwr_ctrl_wbuf2.sv
// svmr_wbuf2: two-entry output buffer between the FIFO read port and the W channel; slot 0 is the head.
module svmr_wbuf2 #(
    parameter int W = 512
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign count_o = count_q;
    assign head_o  = slot0_q;

    // Simultaneous write and pop keeps the count; the head only moves on a pop
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({wr_i, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = wdata_i;
                end else if (count_q == 2'd1) begin
                    slot1_d = wdata_i;
                end
                if (count_q != 2'd2) begin
                    count_d = count_q + 2'd1;
                end
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = wdata_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = wdata_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/save_mtxreg_ddrwr_ctrl.sv
// Streams matrix-register FIFO data to DDR as single-outstanding AXI write bursts.
// Define SVMR_BRESP_CHK_EN to flag non-OKAY write responses on err_o and abort the command.
module save_mtxreg_ddrwr_ctrl
    import save_mtxreg_ddrwr_ctrl_pkg::*;
#(
    parameter int DDRIF_DATA_WTH = 512,
    parameter int ADDR_WTH       = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    save_mtxreg_ddrwr_ctrl_if.master bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int CNT_W      = $clog2(MAX_BURST) + 1;
    localparam int BEAT_BYTES = DDRIF_DATA_WTH / 8;

    svmr_state_e               state_q, state_d;
    logic [ADDR_WTH-1:0]       addr_q, addr_d;
    logic [15:0]               remain_q, remain_d;
    logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
    logic                      inflight_q;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      ready_en_q;

    logic [CNT_W-1:0]          burst_len;
    logic [1:0]                buf_count;
    logic [DDRIF_DATA_WTH-1:0] buf_head;
    logic                      cmd_ready, rd_en, w_valid, w_pop, w_last, resp_err;

    assign burst_len = (remain_q > 16'(MAX_BURST)) ? CNT_W'(MAX_BURST) : remain_q[CNT_W-1:0];
    assign cmd_ready = (state_q == IDLE) && ready_en_q;
    assign w_valid   = (buf_count != 2'd0);
    assign w_pop     = w_valid && bus.w_ready_i;
    assign w_last    = w_valid && (wr_cnt_q == burst_len - 1'b1);

    // Room check counts the read already in flight and credits a pop happening this cycle
    assign rd_en = (state_q == DATA) && !bus.mtxreg_data_empty_i && (rd_cnt_q < burst_len) &&
                   (({1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, w_pop}) < 3'd2);

`ifdef SVMR_BRESP_CHK_EN
    assign resp_err = (bus.b_resp_i != SVMR_RESP_OKAY);
`else
    assign resp_err = 1'b0;
`endif

    svmr_wbuf2 #(.W(DDRIF_DATA_WTH)) u_wbuf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_i    (inflight_q),
        .wdata_i (bus.fifo_rdata_i),
        .pop_i   (w_pop),
        .count_o (buf_count),
        .head_o  (buf_head)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready) begin
                    if (bus.cmd_len_i != 16'd0) begin
                        addr_d   = bus.cmd_addr_i;
                        remain_d = bus.cmd_len_i;
                        state_d  = ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (bus.aw_ready_i) begin
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (w_pop) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (w_last) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.b_valid_i) begin
                    remain_d = remain_q - 16'(burst_len);
                    addr_d   = addr_q + ADDR_WTH'(burst_len) * ADDR_WTH'(BEAT_BYTES);
                    if (resp_err) begin
                        err_d = 1'b1;
                    end
                    if (resp_err || (remain_d == 16'd0)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= rd_en;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    assign bus.cmd_ready_o      = cmd_ready;
    assign bus.mtxreg_data_re_o = rd_en;
    assign bus.aw_valid_o       = (state_q == ADDR);
    assign bus.aw_addr_o        = addr_q;
    assign bus.aw_len_o         = 8'(burst_len - 1'b1);
    assign bus.w_valid_o        = w_valid;
    assign bus.w_data_o         = buf_head;
    assign bus.w_last_o         = w_last;
    assign bus.b_ready_o        = (state_q == RESP);
    assign busy_o               = (state_q != IDLE);
    assign done_o               = done_q;
    assign err_o                = err_q;

endmodule

// File: tb/tb_save_mtxreg_ddrwr_ctrl.sv
// Directed bench for save_mtxreg_ddrwr_ctrl: FIFO/AXI responder driven per cycle, checks by immediate assertion.
module tb_save_mtxreg_ddrwr_ctrl;

    localparam int DW = 512;
    localparam int AW = 32;

    logic clk;
    logic rstn;
    logic busy, done, err;

    save_mtxreg_ddrwr_ctrl_if #(.DDRIF_DATA_WTH(DW), .ADDR_WTH(AW)) bus ();

    save_mtxreg_ddrwr_ctrl #(
        .DDRIF_DATA_WTH (DW),
        .ADDR_WTH       (AW),
        .MAX_BURST      (16)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compCnt, failCnt, cycleCnt;
    int readIdx, wIdx, reIdxPrev;
    bit rePrev, cmdPending, bPending, toggleReady;
    int emptyHold, emptyTrig;
    logic [1:0] firstResp;
    int awCnt, bCnt, doneCnt, wBeats, lastCnt, wInBurst, stallCnt, readBase;
    logic [7:0] curLen;
    logic [AW-1:0] awAddrLog [8];
    logic [7:0] awLenLog [8];
    int cmdHsCycle, bCycle, doneCycle, firstWCycle, lastWCycle;

    function automatic logic [DW-1:0] beatData(int idx);
        logic [DW-1:0] d;
        logic [31:0] lo;
        lo = 32'hD000_0000 + 32'(idx);
        d = '0;
        d[31:0] = lo;
        d[DW-1:DW-32] = ~lo;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then log handshakes that the next rising edge takes
    task automatic runCycle();
        @(negedge clk);
        if (rePrev) bus.fifo_rdata_i = beatData(reIdxPrev);
        rePrev = 1'b0;
        if (emptyTrig >= 0 && readIdx == emptyTrig) begin
            emptyHold = 5;
            emptyTrig = -1;
        end
        bus.mtxreg_data_empty_i = (emptyHold > 0);
        if (emptyHold > 0) emptyHold--;
        bus.w_ready_i   = toggleReady ? (cycleCnt % 2 == 0) : 1'b1;
        bus.aw_ready_i  = 1'b1;
        bus.b_valid_i   = bPending;
        bus.b_resp_i    = (bCnt == 0) ? firstResp : 2'b00;
        bus.cmd_valid_i = cmdPending;
        #1;
        if (bus.mtxreg_data_re_o) begin
            rePrev = 1'b1;
            reIdxPrev = readIdx;
            readIdx++;
        end
        if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            cmdPending = 1'b0;
            cmdHsCycle = cycleCnt;
        end
        if (bus.aw_valid_o && bus.aw_ready_i) begin
            if (awCnt < 8) begin
                awAddrLog[awCnt] = bus.aw_addr_o;
                awLenLog[awCnt] = bus.aw_len_o;
            end
            awCnt++;
            curLen = bus.aw_len_o;
            wInBurst = 0;
        end
        if (bus.w_valid_o) begin
            checkOutput("w_data", bus.w_data_o, beatData(wIdx));
            checkOutput("w_last", bus.w_last_o, (wInBurst == int'(curLen)));
            if (bus.w_ready_i) begin
                if (wBeats == 0) firstWCycle = cycleCnt;
                lastWCycle = cycleCnt;
                wIdx++;
                wBeats++;
                wInBurst++;
                if (bus.w_last_o) begin
                    lastCnt++;
                    bPending = 1'b1;
                end
            end else begin
                stallCnt++;
            end
        end
        if (bus.b_valid_i && bus.b_ready_o) begin
            bPending = 1'b0;
            bCnt++;
            bCycle = cycleCnt;
        end
        if (done) begin
            doneCnt++;
            doneCycle = cycleCnt;
        end
        cycleCnt++;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [15:0] len,
                                 input logic [1:0] resp0, input bit toggle, input int emptyAfter);
        bus.cmd_addr_i = addr;
        bus.cmd_len_i  = len;
        firstResp   = resp0;
        toggleReady = toggle;
        emptyHold   = 0;
        emptyTrig   = (emptyAfter >= 0) ? readIdx + emptyAfter : -1;
        awCnt = 0; bCnt = 0; doneCnt = 0; wBeats = 0; lastCnt = 0; stallCnt = 0;
        wIdx = readIdx;
        readBase = readIdx;
        cmdPending = 1'b1;
    endtask

    task automatic waitDone(input int maxCyc);
        for (int n = 0; n < maxCyc && doneCnt == 0; n++) runCycle();
        checkOutput("done_seen", (doneCnt != 0), 1'b1);
        repeat (3) runCycle();
    endtask

    initial begin
        compCnt = 0; failCnt = 0; cycleCnt = 0;
        readIdx = 0; wIdx = 0; reIdxPrev = 0;
        rePrev = 0; cmdPending = 0; bPending = 0; toggleReady = 0;
        emptyHold = 0; emptyTrig = -1; firstResp = 2'b00;
        awCnt = 0; bCnt = 0; doneCnt = 0; wBeats = 0; lastCnt = 0; wInBurst = 0; stallCnt = 0;
        readBase = 0; curLen = 8'd0;
        cmdHsCycle = 0; bCycle = 0; doneCycle = 0; firstWCycle = 0; lastWCycle = 0;
        rstn = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
        bus.mtxreg_data_empty_i = 1'b0; bus.fifo_rdata_i = '0;
        bus.aw_ready_i = 1'b0; bus.w_ready_i = 1'b0; bus.b_valid_i = 1'b0; bus.b_resp_i = 2'b00;

        // Reset state and cmd_ready release
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_outputs", {bus.cmd_ready_o, bus.aw_valid_o, bus.w_valid_o, bus.mtxreg_data_re_o,
                                    bus.b_ready_o, done, busy, err}, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("ready_before_edge", bus.cmd_ready_o, 1'b0);
        runCycle();
        checkOutput("ready_after_rst", bus.cmd_ready_o, 1'b1);

        $display("[TB] single 16-beat burst at 0x1000");
        applyStimulus(32'h0000_1000, 16'd16, 2'b00, 1'b0, -1);
        waitDone(200);
        checkOutput("t1_aw_cnt", awCnt, 1);
        checkOutput("t1_aw_addr", awAddrLog[0], 32'h0000_1000);
        checkOutput("t1_aw_len", awLenLog[0], 8'd15);
        checkOutput("t1_beats", wBeats, 16);
        checkOutput("t1_last_cnt", lastCnt, 1);
        checkOutput("t1_b2b_span", lastWCycle - firstWCycle, 15);
        checkOutput("t1_reads", readIdx - readBase, 16);
        checkOutput("t1_done_cnt", doneCnt, 1);
        checkOutput("t1_done_lat", doneCycle - bCycle, 1);
        checkOutput("t1_busy_end", busy, 1'b0);

        $display("[TB] 40 beats split into 16/16/8");
        applyStimulus(32'h0000_0000, 16'd40, 2'b00, 1'b0, -1);
        waitDone(400);
        checkOutput("t2_aw_cnt", awCnt, 3);
        checkOutput("t2_aw0", {awAddrLog[0], awLenLog[0]}, {32'h0000_0000, 8'd15});
        checkOutput("t2_aw1", {awAddrLog[1], awLenLog[1]}, {32'h0000_0400, 8'd15});
        checkOutput("t2_aw2", {awAddrLog[2], awLenLog[2]}, {32'h0000_0800, 8'd7});
        checkOutput("t2_b_cnt", bCnt, 3);
        checkOutput("t2_beats", wBeats, 40);
        checkOutput("t2_last_cnt", lastCnt, 3);
        checkOutput("t2_done_cnt", doneCnt, 1);
        checkOutput("t2_done_lat", doneCycle - bCycle, 1);

        $display("[TB] w_ready toggling with a 5-cycle FIFO empty gap");
        applyStimulus(32'h0000_3000, 16'd8, 2'b00, 1'b1, 3);
        waitDone(300);
        checkOutput("t3_aw", {awAddrLog[0], awLenLog[0]}, {32'h0000_3000, 8'd7});
        checkOutput("t3_beats", wBeats, 8);
        checkOutput("t3_reads", readIdx - readBase, 8);
        checkOutput("t3_stalled", (stallCnt > 0), 1'b1);
        checkOutput("t3_done_cnt", doneCnt, 1);
        toggleReady = 1'b0;

        $display("[TB] zero-length command");
        applyStimulus(32'h0000_5000, 16'd0, 2'b00, 1'b0, -1);
        waitDone(50);
        checkOutput("t4_aw_cnt", awCnt, 0);
        checkOutput("t4_reads", readIdx - readBase, 0);
        checkOutput("t4_done_cnt", doneCnt, 1);
        checkOutput("t4_done_lat", doneCycle - cmdHsCycle, 1);

        $display("[TB] error response on first burst of 32 beats");
        applyStimulus(32'h0000_4000, 16'd32, 2'b10, 1'b0, -1);
        waitDone(400);
        checkOutput("t5_done_cnt", doneCnt, 1);
        checkOutput("t5_busy_end", busy, 1'b0);
`ifdef SVMR_BRESP_CHK_EN
        checkOutput("t5_aw_cnt", awCnt, 1);
        checkOutput("t5_err", err, 1'b1);
        checkOutput("t5_reads", readIdx - readBase, 16);
`else
        checkOutput("t5_aw_cnt", awCnt, 2);
        checkOutput("t5_aw1_addr", awAddrLog[1], 32'h0000_4400);
        checkOutput("t5_err", err, 1'b0);
        checkOutput("t5_reads", readIdx - readBase, 32);
`endif

        $display("[TB] reset during beat 5 of 16");
        applyStimulus(32'h0000_1000, 16'd16, 2'b00, 1'b0, -1);
        for (int n = 0; n < 100 && wBeats < 4; n++) runCycle();
        checkOutput("t6_reached_beat5", wBeats, 4);
        @(negedge clk);
        rstn = 1'b0;
        rePrev = 1'b0; bPending = 1'b0; cmdPending = 1'b0;
        bus.cmd_valid_i = 1'b0;
        #1;
        checkOutput("t6_rst_outputs", {bus.cmd_ready_o, bus.aw_valid_o, bus.w_valid_o, bus.mtxreg_data_re_o,
                                       bus.b_ready_o, done, busy, err}, 8'h00);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        readBase = readIdx;
        runCycle();
        runCycle();
        checkOutput("t6_no_reads_after", readIdx - readBase, 0);
        checkOutput("t6_ready_after", bus.cmd_ready_o, 1'b1);

        $display("[TB] 20 beats across the top of the address space");
        applyStimulus(32'hFFFF_FC00, 16'd20, 2'b00, 1'b0, -1);
        waitDone(300);
        checkOutput("t7_aw_cnt", awCnt, 2);
        checkOutput("t7_aw0", {awAddrLog[0], awLenLog[0]}, {32'hFFFF_FC00, 8'd15});
        checkOutput("t7_aw1_wrap", {awAddrLog[1], awLenLog[1]}, {32'h0000_0000, 8'd3});
        checkOutput("t7_beats", wBeats, 20);
        checkOutput("t7_done_cnt", doneCnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
